clock_time_ctrl: RTL and testbench

//   Time-keeping and set-mode controller for the VGA clock display. Generates the

---
 rtl/clock_pkg.sv | 34 +++
 rtl/btn_edge.sv | 34 +++
 rtl/clock_time_ctrl.sv | 105 ++++++++++
 tb/tb_clock_time_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared encodings, field limits and helpers for the clock time-keeping controller.
package clock_pkg;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HR_W    = 5;
  localparam int FIELD_W = 6;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10,
    MODE_SET_SEC = 2'b11
  } mode_e;

  function automatic logic [FIELD_W-1:0] inc_wrap(input logic [FIELD_W-1:0] val,
                                                  input logic [FIELD_W-1:0] max);
    return (val == max) ? '0 : val + 1'b1;
  endfunction

  function automatic mode_e next_mode(input mode_e cur);
    case (cur)
      MODE_RUN:     return MODE_SET_HR;
      MODE_SET_HR:  return MODE_SET_MIN;
      MODE_SET_MIN: return MODE_SET_SEC;
      default:      return MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer plus delay flop giving a one-cycle pulse per button press.
module btn_edge (
  input  logic CLK,
  input  logic RST_BTN,
  input  logic btn_i,
  output logic rise_o
);

  logic sync1_q, sync2_q, dly_q;
  logic warm1_q, warm2_q, armed_q;

  // Edges stay suppressed until the synchronized level has been seen low once
  // after reset, so a button still held at release never fires.
  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
      warm1_q <= 1'b0;
      warm2_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      warm1_q <= 1'b1;
      warm2_q <= warm1_q;
      armed_q <= armed_q | (warm2_q & ~sync2_q);
    end
  end

  assign rise_o = sync2_q & ~dly_q & armed_q;

endmodule

// File: rtl/clock_time_ctrl.sv
// Time-keeping and set-mode controller: 1 Hz prescaler, HH:MM:SS counters with
// carry chain, and a four-state mode FSM driven by two push-buttons.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic             CLK,
  input  logic             RST_BTN,
  input  logic             btn_mode,
  input  logic             btn_inc,
  output logic [SEC_W-1:0] seconds,
  output logic [MIN_W-1:0] minutes,
  output logic [HR_W-1:0]  hours,
  output logic [1:0]       mode,
  output logic             tick_1hz
);

  localparam int               PRE_W   = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic mode_edge, inc_edge, inc_ok, wrap;

  mode_e            mode_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [HR_W-1:0]  hr_q, hr_d;

  btn_edge u_mode_edge (
    .CLK     (CLK),
    .RST_BTN (RST_BTN),
    .btn_i   (btn_mode),
    .rise_o  (mode_edge)
  );

  btn_edge u_inc_edge (
    .CLK     (CLK),
    .RST_BTN (RST_BTN),
    .btn_i   (btn_inc),
    .rise_o  (inc_edge)
  );

  assign wrap   = (mode_q == MODE_RUN) && (pre_q == PRE_MAX);
  assign inc_ok = inc_edge & ~mode_edge;

  // NOTE: every variable gets its default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    pre_d = '0;
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (mode_q == MODE_RUN && !mode_edge && !wrap) pre_d = pre_q + 1'b1;
    case (mode_q)
      MODE_RUN: begin
        if (wrap) begin
          sec_d = inc_wrap(sec_q, SEC_MAX);
          if (sec_q == SEC_MAX) begin
            min_d = inc_wrap(min_q, MIN_MAX);
            if (min_q == MIN_MAX) hr_d = HR_W'(inc_wrap(FIELD_W'(hr_q), FIELD_W'(HR_MAX)));
          end
        end
      end
      MODE_SET_HR:  if (inc_ok) hr_d  = HR_W'(inc_wrap(FIELD_W'(hr_q), FIELD_W'(HR_MAX)));
      MODE_SET_MIN: if (inc_ok) min_d = inc_wrap(min_q, MIN_MAX);
      MODE_SET_SEC: if (inc_ok) sec_d = inc_wrap(sec_q, SEC_MAX);
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      mode_q <= MODE_RUN;
    end else if (mode_edge) begin
      mode_q <= next_mode(mode_q);
    end
  end

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      sec_q  <= '0;
      min_q  <= '0;
      hr_q   <= '0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= wrap;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hr_q   <= hr_d;
    end
  end

  assign seconds  = sec_q;
  assign minutes  = min_q;
  assign hours    = hr_q;
  assign mode     = mode_q;
  assign tick_1hz = tick_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed self-checking bench for clock_time_ctrl with a 4-cycle second.
module tb_clock_time_ctrl;

  logic       CLK = 1'b0;
  logic       RST_BTN = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic [1:0] mode;
  logic       tick_1hz;

  int n_cmp = 0;
  int n_err = 0;
  int tick_cnt = 0;

  always #5 CLK = ~CLK;

  clock_time_ctrl #(.TICK_DIV(4)) dut (
    .CLK      (CLK),
    .RST_BTN  (RST_BTN),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .seconds  (seconds),
    .minutes  (minutes),
    .hours    (hours),
    .mode     (mode),
    .tick_1hz (tick_1hz)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, "_hr"},  32'(hours),   32'(h));
    check({tag, "_min"}, 32'(minutes), 32'(m));
    check({tag, "_sec"}, 32'(seconds), 32'(s));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge CLK);
      if (tick_1hz) tick_cnt++;
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    cyc(3);
    btn_mode = 1'b0;
    cyc(3);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      btn_inc = 1'b1;
      cyc(3);
      btn_inc = 1'b0;
      cyc(3);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_BTN = 1'b0;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    @(negedge CLK);
    RST_BTN = 1'b1;
  endtask

  // Mode press lands on the 4th edge after release, together with the first tick.
  task automatic enter_set_from_reset();
    do_reset();
    cyc(1);
    btn_mode = 1'b1;
    cyc(3);
    check("enter_mode", 32'(mode), 32'd1);
    check("enter_tick_same_edge", 32'(tick_1hz), 32'd1);
    check_time("enter", 0, 0, 1);
    btn_mode = 1'b0;
    cyc(1);
    check("enter_tick_drop", 32'(tick_1hz), 32'd0);
    cyc(2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Test 1: reset state and free-running tick.
    #3;
    check_time("rst", 0, 0, 0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_tick", 32'(tick_1hz), 32'd0);
    @(negedge CLK);
    RST_BTN = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      check("t1_tick", 32'(tick_1hz), (i % 4 == 0) ? 32'd1 : 32'd0);
    end
    check_time("t1", 0, 0, 4);
    check("t1_mode", 32'(mode), 32'd0);

    // Test 3: hours wrap past 23 with no tick in set mode.
    enter_set_from_reset();
    tick_cnt = 0;
    press_inc(25);
    check_time("t3", 1, 0, 1);
    check("t3_no_tick", 32'(tick_cnt), 32'd0);
    press_inc(22);
    check("t3_hr23", 32'(hours), 32'd23);

    // Test 4: simultaneous mode and inc edges -> inc dropped.
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    cyc(3);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    cyc(3);
    check("t4_mode", 32'(mode), 32'd2);
    check_time("t4", 23, 0, 1);

    press_inc(59);
    check("t2_min59", 32'(minutes), 32'd59);
    press_mode();
    check("t5_mode", 32'(mode), 32'd3);

    // Test 5: held inc gives one increment, two edges after the first sample.
    btn_inc = 1'b1;
    cyc(2);
    check("t5_latency_early", 32'(seconds), 32'd1);
    cyc(1);
    check("t5_latency_hit", 32'(seconds), 32'd2);
    cyc(17);
    check("t5_no_repeat", 32'(seconds), 32'd2);
    btn_inc = 1'b0;
    cyc(3);

    // Test 2: 23:59:59 rolls over on the first tick after returning to RUN.
    press_inc(57);
    check_time("t2_pre", 23, 59, 59);
    btn_mode = 1'b1;
    cyc(3);
    check("t2_run", 32'(mode), 32'd0);
    check("t2_tick_entry", 32'(tick_1hz), 32'd0);
    btn_mode = 1'b0;
    tick_cnt = 0;
    cyc(3);
    check_time("t2_wait", 23, 59, 59);
    check("t2_no_early_tick", 32'(tick_cnt), 32'd0);
    cyc(1);
    check_time("t2_roll", 0, 0, 0);
    check("t2_tick", 32'(tick_1hz), 32'd1);

    // Test 6: async reset from SET_MIN at 12:34:56, mid-press.
    enter_set_from_reset();
    press_inc(12);
    press_mode();
    press_inc(34);
    press_mode();
    press_inc(54);
    press_mode();
    press_mode();
    check("t6_mode_hr", 32'(mode), 32'd1);
    check("t6_sec_run_tick", 32'(seconds), 32'd56);
    press_mode();
    check("t6_mode_min", 32'(mode), 32'd2);
    check_time("t6_pre", 12, 34, 56);
    btn_inc = 1'b1;
    cyc(1);
    #2;
    RST_BTN = 1'b0;
    #1;
    check_time("t6_async", 0, 0, 0);
    check("t6_async_mode", 32'(mode), 32'd0);
    check("t6_async_tick", 32'(tick_1hz), 32'd0);
    btn_inc = 1'b0;
    btn_mode = 1'b1;
    @(negedge CLK);
    RST_BTN = 1'b1;
    cyc(10);
    check("t6_held_no_edge", 32'(mode), 32'd0);
    btn_mode = 1'b0;
    cyc(4);
    press_mode();
    check("t6_rearmed", 32'(mode), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
